bcd_to_bin_encoder: RTL and testbench
=====================================

Name: bcd_to_bin_encoder

Overview:
- Sequential packed-BCD to binary converter for the clock/date/timer datapath.
- Takes one BCD byte, for example a register value read from the RTC chip (hours, minutes, day, month, timer fields), and returns the 8-bit binary count value used by the counters.
- Uses a start/done handshake, a fixed-latency reverse double-dabble (shift right, then subtract 3), digit validation and a per-field range check against a caller-supplied maximum.

Parameters:
- DIGITS, 2: number of packed BCD digits. The input is 4*DIGITS bits wide. Only DIGITS=2 is verified.
- W_BIN, 8: binary output width. It must be at least ceil(log2(10^DIGITS)).
- ITER, 4*DIGITS: number of shift iterations. Derived; do not override.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a conversion. Sampled only when busy=0.
- bcd_in  in  4*DIGITS  packed BCD; [7:4] is tens, [3:0] is units. Captured on the accepted start.
- max_val  in  W_BIN  inclusive upper bound for the field (e.g. 23, 59, 31, 12). Captured with bcd_in.
- busy  out  1  high from the accept edge until done deasserts.
- done  out  1  one-cycle pulse; bin_out and err are valid in this cycle.
- err  out  1  result invalid (bad digit or out of range). Meaningful with done, held until the next done.
- bin_out  out  W_BIN  binary result. Held until the next done; 0 when err=1.

Behaviour:
- Reset: the FSM goes to IDLE and busy, done, err, bin_out and the iteration counter all go to 0. A reset during SHIFT or DONE aborts the conversion: no done pulse and no output update.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - If start=1 on edge k: capture bcd_in into the work register BCD, clear the binary register BIN, capture max_val, set cnt=0, go to SHIFT, set busy=1.
  - If start=0: stay in IDLE.
- Digit validation happens at capture: any captured nibble greater than 9 sets the internal flag bad=1. The conversion still runs, so latency stays fixed.
- SHIFT (edges k+1 .. k+ITER), each edge:
  - {BCD,BIN} is shifted right by 1. The LSB of BCD enters the MSB of BIN.
  - Then every BCD nibble that is 8 or more after the shift has 3 subtracted from it.
  - Then cnt increments.
  - When cnt reaches ITER-1, go to DONE.
- DONE register (edge k+ITER+1):
  - done=1 for exactly one cycle.
  - err = bad OR (BIN > max_val). Both are compared unsigned at W_BIN width.
  - bin_out = err ? 0 : BIN.
  - Go to IDLE. busy drops on the same edge that clears done.
- Latency: done is high in the clock cycle after edge k+9 (for DIGITS=2). That is 9 edges after start is sampled. Throughput is one conversion per 10 cycles.
- A start asserted while busy=1 (SHIFT or DONE) is ignored and not queued.
- If start is held high continuously, the next accept happens on the first edge seen in IDLE, i.e. the edge after done.
- Boundary values:
  - 0x00 gives 0.
  - 0x99 gives 99 (0x63) when max_val is at least 99.
  - max_val=0 rejects every nonzero value.
- bcd_in and max_val may change freely while busy; only the captured copies are used.

Decomposition:
- Shared package (bcd_pkg):
  - State encoding constants ST_IDLE, ST_SHIFT, ST_DONE.
  - DIGITS_DEF=2, W_BIN_DEF=8.
  - BCD_MAX_DIGIT=9.
  - Field limit constants: MAX_HORA=23, MAX_MIN=59, MAX_DIA=31, MAX_MES=12, MAX_ANO=99.
- Sub-module bcd_digit_corrector:
  - Combinational, one per nibble via generate.
  - in[3:0] -> out = (in >= 8) ? in - 3 : in.
  - The same module is reusable for the validity compare (in > 9).

Test Plan:
1. Reset, then start with bcd_in=0x59, max_val=59 -> done exactly 9 edges later with bin_out=0x3B, err=0; busy high for 10 cycles.
2. bcd_in=0x24, max_val=23 (MAX_HORA) -> done with err=1 and bin_out=0. Then bcd_in=0x23 -> bin_out=0x17, err=0.
3. bcd_in=0x3A and then 0xA1, max_val=99 -> err=1 and bin_out=0 for both, with the same 9-edge latency.
4. Sweep bcd_in over all 100 valid codes 0x00..0x99 with max_val=99 -> bin_out equals the decimal value and err=0 each time. The bin_out values also round-trip through the binary-to-BCD decoder.
5. Accept 0x12, pulse start with 0x45 during SHIFT, hold start high through DONE -> first result is 0x0C. The 0x45 start is ignored. A second conversion is accepted on the edge after done, using the bcd_in present at that edge.
6. Assert reset on the 4th SHIFT edge -> busy, done, err and bin_out are all 0 on the next edge. There is no done pulse. The next start on 0x07 gives bin_out=0x07 normally.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary conversion path.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DIGITS_DEF    = 2;
  localparam int W_BIN_DEF     = 8;
  localparam int BCD_MAX_DIGIT = 9;

  // Inclusive upper bounds of the RTC fields.
  localparam logic [7:0] MAX_HORA = 8'd23;
  localparam logic [7:0] MAX_MIN  = 8'd59;
  localparam logic [7:0] MAX_DIA  = 8'd31;
  localparam logic [7:0] MAX_MES  = 8'd12;
  localparam logic [7:0] MAX_ANO  = 8'd99;

endpackage

// File: rtl/bcd_digit_corrector.sv
// One BCD nibble: reverse double-dabble adjust (>=8 -> -3) and a digit-validity flag.
module bcd_digit_corrector
  import bcd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] adj,
  output logic       gt9
);

  assign adj = (nib >= 4'd8) ? nib - 4'd3 : nib;
  assign gt9 = (nib > 4'(BCD_MAX_DIGIT));

endmodule

// File: rtl/bcd_to_bin_encoder.sv
// Fixed-latency packed-BCD to binary converter with start/done handshake,
// digit validation and a range check against a captured field maximum.
module bcd_to_bin_encoder
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int W_BIN  = W_BIN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic [W_BIN-1:0]    max_val,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [W_BIN-1:0]    bin_out
);

  localparam int ITER = 4 * DIGITS;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  state_t              state, state_nx;
  logic [ITER-1:0]     bcd_q;
  logic [ITER-1:0]     bin_q;
  logic [W_BIN-1:0]    max_q;
  logic                bad_q;
  logic [CW-1:0]       cnt;

  logic [ITER-1:0]     shifted;
  logic [ITER-1:0]     corr_in;
  logic [ITER-1:0]     corrected;
  logic [DIGITS-1:0]   nib_bad;
  logic                last_iter;
  logic [W_BIN-1:0]    result;
  logic                res_err;

  assign shifted   = bcd_q >> 1;
  assign last_iter = (cnt == CW'(ITER - 1));
  assign result    = W_BIN'(bin_q);
  assign res_err   = bad_q | (result > max_q);

  // The correctors validate the incoming byte while idle and adjust the
  // shifted work register during the conversion, so one bank serves both.
  assign corr_in = (state == ST_IDLE) ? bcd_in : shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_corrector u_corr (
      .nib (corr_in[4*g +: 4]),
      .adj (corrected[4*g +: 4]),
      .gt9 (nib_bad[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      ST_IDLE:  if (start)     state_nx = ST_SHIFT;
      ST_SHIFT: if (last_iter) state_nx = ST_DONE;
      ST_DONE:                 state_nx = ST_IDLE;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      max_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // busy is only still high here during the done cycle.
          busy <= start;
          if (start) begin
            bcd_q <= bcd_in;
            bin_q <= '0;
            max_q <= max_val;
            bad_q <= |nib_bad;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          bcd_q <= corrected;
          bin_q <= {bcd_q[0], bin_q[ITER-1:1]};
          cnt   <= cnt + 1'b1;
        end
        ST_DONE: begin
          done    <= 1'b1;
          err     <= res_err;
          bin_out <= res_err ? '0 : result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_encoder.sv
// Directed bench for bcd_to_bin_encoder: latency, range/digit errors, full sweep,
// ignored starts while busy, held start, and reset abort.
module tb_bcd_to_bin_encoder;
  import bcd_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] bcd_in;
  logic [7:0] max_val;
  logic       busy, done, err;
  logic [7:0] bin_out;

  int total = 0;
  int bad   = 0;

  bcd_to_bin_encoder #(.DIGITS(2), .W_BIN(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .max_val (max_val),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one conversion; inputs are scrambled while busy to prove the copies are used.
  task automatic convert(input logic [7:0] b, input logic [7:0] m,
                         output int lat, output logic [7:0] bo, output logic e,
                         output int bcnt, output logic b_after);
    @(negedge clk);
    bcd_in = b; max_val = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bcd_in = 8'hFF; max_val = 8'h00;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    bo = bin_out; e = err;
    @(posedge clk); #1;
    b_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bcd_in = 8'h00; max_val = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (bin_out !== 8'h0) begin bad++; $display("FAIL reset_bin got=%h exp=00", bin_out); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bcnt; logic [7:0] bo; logic e, ba;
    convert(8'h59, MAX_MIN, lat, bo, e, bcnt, ba);
    total++; if (lat !== 9)      begin bad++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    total++; if (bo !== 8'h3B)   begin bad++; $display("FAIL basic_bin got=%h exp=3b", bo); end
    total++; if (e !== 1'b0)     begin bad++; $display("FAIL basic_err got=%b exp=0", e); end
    total++; if (bcnt !== 10)    begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=10", bcnt); end
    total++; if (ba !== 1'b0)    begin bad++; $display("FAIL basic_busy_after got=%b exp=0", ba); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    total++; if (bin_out !== 8'h3B) begin bad++; $display("FAIL basic_bin_hold got=%h exp=3b", bin_out); end
  endtask

  task automatic test_range();
    int lat, bcnt; logic [7:0] bo; logic e, ba;
    convert(8'h24, MAX_HORA, lat, bo, e, bcnt, ba);
    total++; if (e !== 1'b1)   begin bad++; $display("FAIL range_24_err got=%b exp=1", e); end
    total++; if (bo !== 8'h00) begin bad++; $display("FAIL range_24_bin got=%h exp=00", bo); end
    convert(8'h23, MAX_HORA, lat, bo, e, bcnt, ba);
    total++; if (e !== 1'b0)   begin bad++; $display("FAIL range_23_err got=%b exp=0", e); end
    total++; if (bo !== 8'h17) begin bad++; $display("FAIL range_23_bin got=%h exp=17", bo); end
    convert(8'h01, 8'd0, lat, bo, e, bcnt, ba);
    total++; if (e !== 1'b1)   begin bad++; $display("FAIL range_max0_err got=%b exp=1", e); end
    convert(8'h00, 8'd0, lat, bo, e, bcnt, ba);
    total++; if (e !== 1'b0)   begin bad++; $display("FAIL range_zero_err got=%b exp=0", e); end
    total++; if (bo !== 8'h00) begin bad++; $display("FAIL range_zero_bin got=%h exp=00", bo); end
    convert(8'h13, MAX_MES, lat, bo, e, bcnt, ba);
    total++; if (e !== 1'b1)   begin bad++; $display("FAIL range_mes_err got=%b exp=1", e); end
  endtask

  task automatic test_bad_digit();
    int lat, bcnt; logic [7:0] bo; logic e, ba;
    logic [7:0] codes [2] = '{8'h3A, 8'hA1};
    for (int i = 0; i < 2; i++) begin
      convert(codes[i], MAX_ANO, lat, bo, e, bcnt, ba);
      total++; if (e !== 1'b1)   begin bad++; $display("FAIL digit_%h_err got=%b exp=1", codes[i], e); end
      total++; if (bo !== 8'h00) begin bad++; $display("FAIL digit_%h_bin got=%h exp=00", codes[i], bo); end
      total++; if (lat !== 9)    begin bad++; $display("FAIL digit_%h_latency got=%0d exp=9", codes[i], lat); end
    end
  endtask

  task automatic test_sweep();
    int lat, bcnt; logic [7:0] bo; logic e, ba;
    logic [7:0] code, back;
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        code = {4'(t), 4'(u)};
        convert(code, MAX_ANO, lat, bo, e, bcnt, ba);
        back = {4'(bo / 8'd10), 4'(bo % 8'd10)};
        total++; if (bo !== 8'(t*10 + u)) begin bad++; $display("FAIL sweep_%h_bin got=%0d exp=%0d", code, bo, t*10 + u); end
        total++; if (e !== 1'b0)          begin bad++; $display("FAIL sweep_%h_err got=%b exp=0", code, e); end
        total++; if (back !== code)       begin bad++; $display("FAIL sweep_%h_roundtrip got=%h exp=%h", code, back, code); end
        total++; if (lat !== 9)           begin bad++; $display("FAIL sweep_%h_latency got=%0d exp=9", code, lat); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int edge1 = -1, edge2 = -1;
    logic [7:0] bin1 = 8'hEE, bin2 = 8'hEE;
    logic err1 = 1'bx, err2 = 1'bx;
    @(negedge clk);
    bcd_in = 8'h12; max_val = MAX_ANO; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      start = 1'b0; bcd_in = 8'h77;
      if (i == 3) begin start = 1'b1; bcd_in = 8'h45; end
      if (i >= 7 && i <= 10) begin start = 1'b1; bcd_in = (i == 10) ? 8'h34 : 8'h77; end
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (n_done == 1) begin edge1 = i; bin1 = bin_out; err1 = err; end
        else             begin edge2 = i; bin2 = bin_out; err2 = err; end
      end
    end
    start = 1'b0;
    total++; if (edge1 !== 9)    begin bad++; $display("FAIL b2b_first_edge got=%0d exp=9", edge1); end
    total++; if (bin1 !== 8'h0C) begin bad++; $display("FAIL b2b_first_bin got=%h exp=0c", bin1); end
    total++; if (err1 !== 1'b0)  begin bad++; $display("FAIL b2b_first_err got=%b exp=0", err1); end
    total++; if (edge2 !== 19)   begin bad++; $display("FAIL b2b_second_edge got=%0d exp=19", edge2); end
    total++; if (bin2 !== 8'h22) begin bad++; $display("FAIL b2b_second_bin got=%h exp=22", bin2); end
    total++; if (err2 !== 1'b0)  begin bad++; $display("FAIL b2b_second_err got=%b exp=0", err2); end
    total++; if (n_done !== 2)   begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt, n_done = 0; logic [7:0] bo; logic e, ba;
    @(negedge clk);
    bcd_in = 8'h56; max_val = MAX_ANO; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL abort_err got=%b exp=0", err); end
    total++; if (bin_out !== 8'h0) begin bad++; $display("FAIL abort_bin got=%h exp=00", bin_out); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    total++; if (n_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
    convert(8'h07, MAX_ANO, lat, bo, e, bcnt, ba);
    total++; if (bo !== 8'h07) begin bad++; $display("FAIL abort_next_bin got=%h exp=07", bo); end
    total++; if (e !== 1'b0)   begin bad++; $display("FAIL abort_next_err got=%b exp=0", e); end
    total++; if (lat !== 9)    begin bad++; $display("FAIL abort_next_latency got=%0d exp=9", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_bad_digit();
    test_sweep();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
